// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and beat type for the N:1 pipelined operand select
package mux_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int XFER_CNT_W    = 16;
  localparam int MAX_SEL_W     = 8;

  // One buffered beat at the default datapath geometry; the select field is
  // wide enough for any practical channel count.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
    logic [MAX_SEL_W-1:0]     sel;
    logic                     bad;
  } beat_t;

endpackage

// File: rtl/mux_n_sel.sv
// rtl/mux_n_sel.sv - combinational channel select, channel-1 narrowing and bad-select detect
module mux_n_sel
  import mux_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM_IN   = 4,
  parameter int NARROW_W = 3,
  localparam int SEL_W   = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        sel_data,
  output logic                    bad
);

  // Channel 1 keeps only its low NARROW_W bits; zero means full width.
  localparam logic [WIDTH-1:0] NARROW_MASK =
    (NARROW_W == 0) ? {WIDTH{1'b1}} : ({WIDTH{1'b1}} >> (WIDTH - NARROW_W));

  // Pick the addressed channel; an out-of-range select yields zero and flags bad.
  always_comb begin
    sel_data = '0;
    bad      = 1'b0;
    if (int'(sel) >= NUM_IN) begin
      bad = 1'b1;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (sel == SEL_W'(k)) begin
          sel_data = data[k*WIDTH +: WIDTH];
        end
      end
      if (sel == SEL_W'(1)) begin
        sel_data = data[WIDTH +: WIDTH] & NARROW_MASK;
      end
    end
  end

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// rtl/mux_n_to_1_pipe.sv - N:1 operand select with valid/ready, output register and skid; MUX_XFER_CNT_EN enables xfer_cnt
module mux_n_to_1_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM_IN   = 4,
  parameter int NARROW_W = 3,
  localparam int SEL_W   = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_bad,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_sticky,
  input  logic                    err_clr,
  output logic [XFER_CNT_W-1:0]   xfer_cnt
);

  // Beat at this instance's geometry.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             bad;
  } slot_t;

  slot_t            out_q;
  slot_t            skid_q;
  slot_t            new_beat;
  logic             out_valid_q;
  logic             skid_valid_q;
  logic             err_q;
  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;
  logic             accept;
  logic             drain;

  mux_n_sel #(
    .WIDTH    (WIDTH),
    .NUM_IN   (NUM_IN),
    .NARROW_W (NARROW_W)
  ) u_sel (
    .data     (in_data),
    .sel      (in_sel),
    .sel_data (sel_data),
    .bad      (sel_bad)
  );

  // Ready depends only on registered skid state, never on out_ready.
  assign in_ready = !skid_valid_q && !reset;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  assign new_beat.data = sel_data;
  assign new_beat.sel  = in_sel;
  assign new_beat.bad  = sel_bad;

  assign out_data   = out_q.data;
  assign out_sel    = out_q.sel;
  assign out_bad    = out_q.bad;
  assign out_valid  = out_valid_q;
  assign err_sticky = err_q;

  // Two-entry FIFO: output register in front, skid behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (drain) begin
      // accept cannot coincide with a full skid because in_ready is low then
      if (skid_valid_q) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q <= new_beat;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (!out_valid_q) begin
      if (accept) begin
        out_q       <= new_beat;
        out_valid_q <= 1'b1;
      end
    end else if (accept) begin
      skid_q       <= new_beat;
      skid_valid_q <= 1'b1;
    end
  end

  // Sticky illegal-select flag; a new bad accept beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept && sel_bad) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

`ifdef MUX_XFER_CNT_EN
  logic [XFER_CNT_W-1:0] cnt_q;

  // Saturating count of accepted transfers, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept && (cnt_q != {XFER_CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// tb/tb_mux_n_to_1_pipe.sv - randomized and directed check of mux_n_to_1_pipe against a FIFO model
module tb_mux_n_to_1_pipe;

  localparam int NW = 3;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        bad;
  } mbeat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] in_data = '0;
  logic [1:0]   in_sel = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         err_clr = 1'b0;

  logic        rdy4, ov4, bad4, err4;
  logic [31:0] od4;
  logic [1:0]  os4;
  logic [15:0] cnt4;
  logic        rdy3, ov3, bad3, err3;
  logic [31:0] od3;
  logic [1:0]  os3;
  logic [15:0] cnt3;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b1;

  mbeat_t q4[$];
  mbeat_t q3[$];
  logic   m_err4, m_err3;
  int     m_cnt;

  always #5 clk = ~clk;

  mux_n_to_1_pipe #(.WIDTH(32), .NUM_IN(4), .NARROW_W(NW)) dut4 (
    .clk(clk), .reset(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(rdy4), .out_data(od4), .out_sel(os4),
    .out_bad(bad4), .out_valid(ov4), .out_ready(out_ready),
    .err_sticky(err4), .err_clr(err_clr), .xfer_cnt(cnt4)
  );

  mux_n_to_1_pipe #(.WIDTH(32), .NUM_IN(3), .NARROW_W(NW)) dut3 (
    .clk(clk), .reset(rst), .in_data(in_data[95:0]), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(rdy3), .out_data(od3), .out_sel(os3),
    .out_bad(bad3), .out_valid(ov3), .out_ready(out_ready),
    .err_sticky(err3), .err_clr(err_clr), .xfer_cnt(cnt3)
  );

  function automatic mbeat_t ref_sel(int n, logic [127:0] d, logic [1:0] s);
    mbeat_t r;
    r.sel = s;
    if (int'(s) >= n) begin
      r.data = 32'h0;
      r.bad  = 1'b1;
    end else begin
      r.data = d[int'(s)*32 +: 32];
      if (s == 2'd1) r.data = r.data & ((32'h1 << NW) - 32'h1);
      r.bad = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each DUT behaves as a 2-deep FIFO.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q4.delete();
      q3.delete();
      m_err4 = 1'b0;
      m_err3 = 1'b0;
      m_cnt  = 0;
    end else begin
      bit acc;
      bit drn;
      mbeat_t b4, b3;
      acc = in_valid && (q4.size() < 2);
      drn = (q4.size() > 0) && out_ready;
      b4 = ref_sel(4, in_data, in_sel);
      b3 = ref_sel(3, in_data, in_sel);
      if (drn) begin
        void'(q4.pop_front());
        void'(q3.pop_front());
      end
      if (acc) begin
        q4.push_back(b4);
        q3.push_back(b3);
        if (m_cnt < 65535) m_cnt++;
      end
      if (acc && b4.bad) m_err4 = 1'b1;
      else if (err_clr)  m_err4 = 1'b0;
      if (acc && b3.bad) m_err3 = 1'b1;
      else if (err_clr)  m_err3 = 1'b0;
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [15:0] ec;
`ifdef MUX_XFER_CNT_EN
      ec = 16'(m_cnt);
`else
      ec = 16'h0;
`endif
      chk("d4_in_ready",  32'(rdy4), 32'(!rst && q4.size() < 2));
      chk("d4_out_valid", 32'(ov4),  32'(q4.size() > 0));
      if (q4.size() > 0) begin
        chk("d4_out_data", od4, q4[0].data);
        chk("d4_out_sel",  32'(os4), 32'(q4[0].sel));
        chk("d4_out_bad",  32'(bad4), 32'(q4[0].bad));
      end
      chk("d4_err", 32'(err4), 32'(m_err4));
      chk("d4_cnt", 32'(cnt4), 32'(ec));
      chk("d3_in_ready",  32'(rdy3), 32'(!rst && q3.size() < 2));
      chk("d3_out_valid", 32'(ov3),  32'(q3.size() > 0));
      if (q3.size() > 0) begin
        chk("d3_out_data", od3, q3[0].data);
        chk("d3_out_sel",  32'(os3), 32'(q3[0].sel));
        chk("d3_out_bad",  32'(bad3), 32'(q3[0].bad));
      end
      chk("d3_err", 32'(err3), 32'(m_err3));
      chk("d3_cnt", 32'(cnt3), 32'(ec));
    end
  end

  initial begin
    step();
    step();
    // reset state
    chk("rst_out_valid", 32'(ov4), 32'h0);
    chk("rst_out_data",  od4, 32'h0);
    chk("rst_out_sel",   32'(os4), 32'h0);
    chk("rst_in_ready",  32'(rdy4), 32'h0);
    chk("rst_err",       32'(err4), 32'h0);
    chk("rst_cnt",       32'(cnt4), 32'h0);
    rst = 1'b0;
    step();

    // single beat
    in_data[64 +: 32] = 32'hDEADBEEF;
    in_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_valid", 32'(ov4), 32'h1);
    chk("single_data",  od4, 32'hDEADBEEF);
    chk("single_sel",   32'(os4), 32'h2);
    step();
    chk("single_gone",  32'(ov4), 32'h0);

    // narrow channel 1
    in_data[32 +: 32] = 32'hFFFFFFFD;
    in_sel = 2'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("narrow_d4", od4, 32'h00000005);
    chk("narrow_d3", od3, 32'h00000005);
    step();

    // backpressure: two accepted, third refused
    in_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    out_ready = 1'b0; in_valid = 1'b1;
    in_sel = 2'd0; step();
    in_sel = 2'd2; step();
    chk("bp_full_rdy", 32'(rdy4), 32'h0);
    in_sel = 2'd3; step();
    chk("bp_hold_sel", 32'(os4), 32'h0);
    chk("bp_still_rdy", 32'(rdy4), 32'h0);
    out_ready = 1'b1; step();
    chk("bp_second_sel", 32'(os4), 32'h2);
    step();
    in_valid = 1'b0;
    chk("bp_third_sel",  32'(os4), 32'h3);
    chk("bp_third_data", od4, 32'h33333333);
    chk("bp_third_bad3", 32'(bad3), 32'h1);
    step();
    chk("bp_empty", 32'(ov4), 32'h0);

    // illegal select on the 3-input instance
    in_sel = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bad_data", od3, 32'h0);
    chk("bad_flag", 32'(bad3), 32'h1);
    chk("bad_err",  32'(err3), 32'h1);
    chk("bad_err4", 32'(err4), 32'h0);
    in_valid = 1'b1; err_clr = 1'b1;
    step();
    in_valid = 1'b0;
    chk("set_wins", 32'(err3), 32'h1);
    step();
    err_clr = 1'b0;
    chk("err_cleared", 32'(err3), 32'h0);

    // async reset with both entries full
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    step(); step();
    in_valid = 1'b0;
    chk("full_rdy", 32'(rdy4), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ov4), 32'h0);
    chk("arst_rdy",   32'(rdy4), 32'h0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_rst_valid", 32'(ov4), 32'h0);
    chk("post_rst_rdy",   32'(rdy4), 32'h1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_sel    = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid = 1'b0; err_clr = 1'b0;

`ifdef MUX_XFER_CNT_EN
    // saturation run
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      in_sel = 2'($urandom_range(0, 3));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("cnt_saturated", 32'(cnt4), 32'h0000FFFF);
`else
    chk("cnt_tied_zero", 32'(cnt4), 32'h0);
`endif

    step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
